// File: rtl/div_unit.sv
// div_unit: iterative 32-bit signed/unsigned radix-2 restoring divider with EX/MEM handshake.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div,
  input  logic        div_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ms_allowin,
  output logic [63:0] div_total_result,
  output logic        complete,
  output logic        es_go,
  output logic        ms_go
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d, res_q, res_d;
  logic [31:0] ya_q, ya_d;
  logic        signed_q, signed_d, xs_q, xs_d, qs_q, qs_d, y0_q, y0_d;
  logic [31:0] xa, yab, q, r;
  logic [64:0] sh, diff;
  logic [63:0] step;
  always_comb begin
    xa       = (div_signed & x[31]) ? -x : x;
    yab      = (div_signed & y[31]) ? -y : y;
    sh       = {rem_q, 1'b0};
    diff     = sh - {1'b0, ya_q, 32'b0};
    // a borrow out of bit 64 means the trial subtraction went negative
    step     = diff[64] ? sh[63:0] : (diff[63:0] | 64'd1);
    q        = step[31:0];
    r        = step[63:32];
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    res_d    = res_q;
    ya_d     = ya_q;
    signed_d = signed_q;
    xs_d     = xs_q;
    qs_d     = qs_q;
    y0_d     = y0_q;
    case (state_q)
      IDLE: if (div) begin
        state_d  = BUSY;
        cnt_d    = 6'd0;
        rem_d    = {32'b0, xa};
        ya_d     = yab;
        signed_d = div_signed;
        xs_d     = x[31];
        qs_d     = x[31] ^ y[31];
        y0_d     = (y == 32'd0);
      end
      BUSY: if (!div) state_d = IDLE;
      else begin
        rem_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          res_d   = {y0_q ? 32'hFFFF_FFFF : ((signed_q & qs_q) ? -q : q),
                     (signed_q & xs_q) ? -r : r};
        end
      end
      DONE: state_d = ms_allowin ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      ya_q     <= '0;
      signed_q <= 1'b0;
      xs_q     <= 1'b0;
      qs_q     <= 1'b0;
      y0_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      ya_q     <= ya_d;
      signed_q <= signed_d;
      xs_q     <= xs_d;
      qs_q     <= qs_d;
      y0_q     <= y0_d;
    end
  end
  assign div_total_result = res_q;
  assign complete         = (state_q == DONE);
  assign es_go            = complete;
  assign ms_go            = complete & ms_allowin;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b1, div = 1'b0, div_signed = 1'b0, ms_allowin = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic [63:0] div_total_result;
  logic        complete, es_go, ms_go;
  int          n_chk = 0, n_pass = 0;
  logic [63:0] last_exp = '0;

  div_unit dut (
    .clk(clk), .rst(rst), .div(div), .div_signed(div_signed), .x(x), .y(y),
    .ms_allowin(ms_allowin), .div_total_result(div_total_result),
    .complete(complete), .es_go(es_go), .ms_go(ms_go)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, qq, rr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    qq = sa / sb;
    rr = sa % sb;
    return {qq, rr};
  endfunction

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] e;
    int cyc;
    e = ref_div(s, a, b);
    div = 1'b1; div_signed = s; x = a; y = b; ms_allowin = (hold == 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      x = $urandom; y = $urandom; div_signed = 1'($urandom);
    end while (!complete && cyc < 100);
    check("latency", 64'(cyc), 64'd33);
    check("result", div_total_result, e);
    check("es_go", 64'(es_go), 64'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_complete", 64'(complete), 64'd1);
      check("hold_ms_go", 64'(ms_go), 64'd0);
      check("hold_result", div_total_result, e);
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    check("ms_go", 64'(ms_go), 64'd1);
    @(negedge clk);
    check("release_complete", 64'(complete), 64'd0);
    check("release_ms_go", 64'(ms_go), 64'd0);
    check("release_result", div_total_result, e);
    div = 1'b0;
    last_exp = e;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", div_total_result, 64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    check("rst_es_go", 64'(es_go), 64'd0);
    check("rst_ms_go", 64'(ms_go), 64'd0);
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 0);
    check("u100_7", last_exp, 64'h0000000E_00000002);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h1234_5678, 32'h0, 0);
    run_op(1'b1, 32'h8765_4321, 32'h0, 1);
    run_op(1'b0, 32'd100, 32'd7, 5);
    // flush mid-BUSY: no completion, result untouched
    div = 1'b1; div_signed = 1'b0; x = 32'd12345; y = 32'd3;
    repeat (10) @(negedge clk);
    div = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_complete", 64'(complete), 64'd0);
      check("abort_result", div_total_result, last_exp);
    end
    run_op(1'b1, 32'hFFFF_FF00, 32'd9, 0);
    // reset mid-BUSY
    div = 1'b1; div_signed = 1'b0; x = 32'd100; y = 32'd7;
    repeat (10) @(negedge clk);
    rst = 1'b1; div = 1'b0;
    @(negedge clk);
    check("mrst_result", div_total_result, 64'd0);
    check("mrst_complete", 64'(complete), 64'd0);
    check("mrst_es_go", 64'(es_go), 64'd0);
    check("mrst_ms_go", 64'(ms_go), 64'd0);
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 0);
    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, b;
      int m;
      a = $urandom;
      m = $urandom_range(0, 4);
      b = (m == 0) ? 32'd0 : (m == 1) ? 32'($urandom_range(1, 255)) :
          (m == 2) ? 32'hFFFF_FFFF : $urandom;
      if (k % 7 == 3) a = 32'h8000_0000;
      run_op(1'($urandom), a, b, $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
